// File: rtl/dp_ram_pkg.sv
// Shared constants and FSM state type for the dual-port RAM slice.
package dp_ram_pkg;

  localparam logic RDW_OLD = 1'b0;
  localparam logic RDW_NEW = 1'b1;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

endpackage

// File: rtl/dp_ram_clr.sv
// Post-reset clear sweep: walks every address once, writing zero, then hands
// the memory over to the ports.
module dp_ram_clr
  import dp_ram_pkg::*;
#(
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic          rst,
  output logic          busy,
  output logic [AW-1:0] clr_addr,
  output logic          clr_we
);

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      // Last word is written on this edge, so leave CLEAR right after it.
      if (cnt_q == {AW{1'b1}}) state_d = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy     = (state_q == CLEAR);
  assign clr_addr = cnt_q;
  assign clr_we   = (state_q == CLEAR);

endmodule

// File: rtl/dp_ram_sync.sv
// Single-clock true dual-port RAM with self-clear, RDW policy and write-collision
// arbitration (port 1 wins). Define DP_RAM_OUTREG_EN for an extra output register.
module dp_ram_sync
  import dp_ram_pkg::*;
#(
  parameter int   DW       = 8,
  parameter int   AW       = 7,
  parameter logic RDW_MODE = RDW_OLD
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en1,
  input  logic          wr1,
  input  logic [AW-1:0] a1,
  input  logic [DW-1:0] d1,
  output logic [DW-1:0] q1,
  input  logic          en2,
  input  logic          wr2,
  input  logic [AW-1:0] a2,
  input  logic [DW-1:0] d2,
  output logic [DW-1:0] q2,
  output logic          busy,
  output logic          coll
);

  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0] mem [DEPTH];

  logic          clr_we;
  logic [AW-1:0] clr_addr;
  logic          run, same_addr, we1, we2;
  logic [DW-1:0] rd1_q, rd1_d, rd2_q, rd2_d;
  logic          coll_q, coll_d;

  dp_ram_clr #(.AW(AW)) u_clr (
    .clk      (clk),
    .rst      (rst),
    .busy     (busy),
    .clr_addr (clr_addr),
    .clr_we   (clr_we)
  );

  // Port 2 loses a same-address write, so only one write lands per address.
  always_comb begin
    run       = !busy && !rst;
    same_addr = (a1 == a2);
    we1       = run && en1 && wr1;
    we2       = run && en2 && wr2 && !(we1 && same_addr);
  end

  always_comb begin
    rd1_d  = rd1_q;
    rd2_d  = rd2_q;
    coll_d = we1 && en2 && wr2 && same_addr;
    if (run && en1) begin
      rd1_d = mem[a1];
      if (RDW_MODE == RDW_NEW) begin
        if (we1)                   rd1_d = d1;
        else if (we2 && same_addr) rd1_d = d2;
      end
    end
    if (run && en2) begin
      rd2_d = mem[a2];
      if (RDW_MODE == RDW_NEW) begin
        if (we1 && same_addr) rd2_d = d1;
        else if (we2)         rd2_d = d2;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else begin
      if (we1) mem[a1] <= d1;
      if (we2) mem[a2] <= d2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd1_q  <= '0;
      rd2_q  <= '0;
      coll_q <= 1'b0;
    end else begin
      rd1_q  <= rd1_d;
      rd2_q  <= rd2_d;
      coll_q <= coll_d;
    end
  end

  assign coll = coll_q;

`ifdef DP_RAM_OUTREG_EN
  // Second stage loads every cycle; only the first stage honours en.
  logic [DW-1:0] oq1_q, oq1_d, oq2_q, oq2_d;

  always_comb begin
    oq1_d = rd1_q;
    oq2_d = rd2_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      oq1_q <= '0;
      oq2_q <= '0;
    end else begin
      oq1_q <= oq1_d;
      oq2_q <= oq2_d;
    end
  end

  assign q1 = oq1_q;
  assign q2 = oq2_q;
`else
  assign q1 = rd1_q;
  assign q2 = rd2_q;
`endif

endmodule
